// File: rtl/led_flash_ctrl.sv
// Switch-to-LED controller: per-channel sync + debounce, mode-selected LED drive,
// and a free-running heartbeat/blink phase shared by the blink and chase modes.
module led_flash_ctrl #(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_HALF      = 25000000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] SWITCH,
  input  logic [1:0]      MODE,
  output logic [N_CH-1:0] LED,
  output logic            HEARTBEAT
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PRE_W = $clog2(BLINK_HALF);
  localparam int unsigned POS_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_HALF - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_CH - 1);

  typedef enum logic [1:0] {
    MODE_FOLLOW = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  deb;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [PRE_W-1:0] presc;
  logic [POS_W-1:0] pos;
  logic             phase;
  logic             wrap_c;
  logic [N_CH-1:0]  chase_c;
  logic [N_CH-1:0]  led_next_c;

  assign HEARTBEAT = phase;
  assign wrap_c    = (presc == PRE_LAST);
  assign chase_c   = N_CH'(1) << pos;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWITCH;
      s2 <= s1;
    end
  end

  // Per-channel debouncer: accept a new level only after it holds for DEBOUNCE_CYCLES.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      deb <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (s2[c] == deb[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CNT_LAST) begin
          deb[c] <= s2[c];
          cnt[c] <= '0;
        end else begin
          cnt[c] <= cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  // Blink prescaler; phase and chase position step on each wrap, independent of mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc <= '0;
      phase <= 1'b0;
      pos   <= '0;
    end else if (wrap_c) begin
      presc <= '0;
      phase <= ~phase;
      pos   <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Mode decode of the next LED pattern from the current debounced state.
  always_comb begin
    led_next_c = deb;
    case (mode_e'(MODE))
      MODE_FOLLOW: led_next_c = deb;
      MODE_INVERT: led_next_c = ~deb;
      MODE_BLINK:  led_next_c = deb & {N_CH{phase}};
      MODE_CHASE:  led_next_c = chase_c & deb;
      default:     led_next_c = deb;
    endcase
  end

  // LED output register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      LED <= '0;
    end else begin
      LED <= led_next_c;
    end
  end

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Scoreboard bench for led_flash_ctrl: stimulus pushes reference-model expectations,
// a monitor pops one per clock edge and compares LED/HEARTBEAT.
module tb_led_flash_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned DC = 4;
  localparam int unsigned BH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw  = '0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] led;
  logic         hb;

  int checks = 0;
  int errors = 0;
  int cur_test = 0;

  typedef struct {
    logic [N-1:0] led;
    logic         hb;
    bit           has_c;
    logic [N-1:0] c_led;
    int           test;
  } exp_t;

  exp_t sbq[$];

  // Reference model state: input pipeline, debounced level, sample window, edges since release.
  logic [N-1:0] m_s1, m_s2, m_deb;
  logic [N-1:0] win[$];
  int unsigned  n_edges;

  led_flash_ctrl #(
    .N_CH(N), .DEBOUNCE_CYCLES(DC), .BLINK_HALF(BH)
  ) dut (
    .CLK(clk), .RESET(rst), .SWITCH(sw), .MODE(mode), .LED(led), .HEARTBEAT(hb)
  );

  always #5 clk = ~clk;

  // A channel's debounced level flips once the last DC synchronised samples all disagree with it.
  // Blink phase and chase slot follow directly from the number of edges since reset release.
  task automatic model_edge(input logic r, input logic [N-1:0] s, input logic [1:0] md,
                            output logic [N-1:0] e_led, output logic e_hb);
    int unsigned blk;
    bit all_diff;
    logic [N-1:0] one;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; n_edges = 0;
      win.delete();
      for (int i = 0; i < int'(DC); i++) win.push_back('0);
      e_led = '0; e_hb = 1'b0;
    end else begin
      blk = n_edges / BH;
      one = '0;
      one[blk % N] = 1'b1;
      case (md)
        2'd0: e_led = m_deb;
        2'd1: e_led = ~m_deb;
        2'd2: e_led = (blk % 2 == 1) ? m_deb : '0;
        default: e_led = one & m_deb;
      endcase
      win.push_back(m_s2);
      void'(win.pop_front());
      for (int c = 0; c < int'(N); c++) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i][c] == m_deb[c]) all_diff = 1'b0;
        if (all_diff) m_deb[c] = ~m_deb[c];
      end
      m_s2 = m_s1;
      m_s1 = s;
      n_edges++;
      e_hb = ((n_edges / BH) % 2) == 1;
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT should show after that edge.
  task automatic step(input logic r, input logic [N-1:0] s, input logic [1:0] md,
                      input bit has_c = 1'b0, input logic [N-1:0] c_led = '0);
    exp_t e;
    @(negedge clk);
    rst = r; sw = s; mode = md;
    model_edge(r, s, md, e.led, e.hb);
    e.has_c = has_c;
    e.c_led = c_led;
    e.test  = cur_test;
    sbq.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL t%0d led: got %b want %b", e.test, led, e.led);
        end
        checks++;
        if (hb !== e.hb) begin
          errors++;
          $display("FAIL t%0d heartbeat: got %b want %b", e.test, hb, e.hb);
        end
        if (e.has_c) begin
          checks++;
          if (led !== e.c_led) begin
            errors++;
            $display("FAIL t%0d led_fixed: got %b want %b", e.test, led, e.c_led);
          end
        end
      end
    end
  end

  initial begin
    int hold;
    logic [N-1:0] rsw;
    logic [1:0]   rmd;
    int guard;

    // 1: reset with switches set, then release and watch the first debounce.
    cur_test = 1;
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1010, 2'd0, 1'b1, 4'b0000);
    for (int k = 1; k <= 12; k++) step(1'b0, 4'b1010, 2'd0, k == 6 || k == 7, (k == 7) ? 4'b1010 : 4'b0000);

    // 2: short glitches on channel 0 are rejected, a steady level is accepted at edge 7.
    cur_test = 2;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3; k++) step(1'b0, 4'b1011, 2'd0, 1'b1, 4'b1010);
      for (int k = 0; k < 3; k++) step(1'b0, 4'b1010, 2'd0, 1'b1, 4'b1010);
    end
    for (int k = 1; k <= 10; k++) step(1'b0, 4'b1011, 2'd0, k == 6 || k == 7, (k == 7) ? 4'b1011 : 4'b1010);

    // 3: inverted mode takes effect on the next edge and back.
    cur_test = 3;
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1010, 2'd0);
    step(1'b0, 4'b1010, 2'd1, 1'b1, 4'b0101);
    step(1'b0, 4'b1010, 2'd0, 1'b1, 4'b1010);

    // 4: blink with all switches on.
    cur_test = 4;
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1111, 2'd0);
    for (int k = 0; k < 20; k++) step(1'b0, 4'b1111, 2'd2);

    // 5: chase, then with one switch off the slot stays dark.
    cur_test = 5;
    for (int k = 0; k < 20; k++) step(1'b0, 4'b1111, 2'd3);
    for (int k = 0; k < 24; k++) step(1'b0, 4'b1011, 2'd3);

    // 6: reset pulse mid-chase at pos 2, then restart.
    cur_test = 6;
    guard = 0;
    while (((n_edges / BH) % N) != 2 && guard < 64) begin
      step(1'b0, 4'b1111, 2'd3);
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL t6 reach_pos2: got guard %0d want <64", guard);
    end
    step(1'b1, 4'b1111, 2'd3, 1'b1, 4'b0000);
    for (int k = 0; k < 20; k++) step(1'b0, 4'b1111, 2'd3);

    // 7: randomized switches, modes and occasional resets.
    cur_test = 7;
    for (int b = 0; b < 120; b++) begin
      rsw  = N'($urandom);
      rmd  = 2'($urandom);
      hold = int'($urandom_range(1, 8));
      for (int k = 0; k < hold; k++) step(($urandom_range(0, 149) == 0), rsw, rmd);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
